// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform source: wave-select codes,
// mid-scale sample value and default datapath widths.
package dds_pkg;

    localparam int ACC_W_DEF  = 16;
    localparam int DATA_W_DEF = 10;
    localparam int FTW_W_DEF  = 10;

    localparam logic [1:0] WAVE_SAW  = 2'b00;
    localparam logic [1:0] WAVE_TRI  = 2'b01;
    localparam logic [1:0] WAVE_SQR  = 2'b10;
    localparam logic [1:0] WAVE_SINE = 2'b11;

    localparam logic [9:0] MIDSCALE = 10'h200;

endpackage

// File: rtl/dds_wavegen_sine_qrom.sv
// Quarter-wave sine magnitude table: 256 entries x 9 bits, combinational.
// Entry i holds round(511 * sin(pi/2 * i/255)), so entry 0 is 0 and
// entry 255 is the full-scale 511. The table is filled at elaboration
// by a constant fixed-point Taylor evaluation, so it synthesises as a ROM.
// Only instantiated when DDS_SINE_EN is defined.
module sine_qrom (
    input  logic [7:0] idx,
    output logic [8:0] mag
);

    // Q30 fixed point sine of (pi/2 * i/255), scaled to 0..511 and rounded.
    function automatic logic [8:0] sine_mag(input int i);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint r;
        x    = (longint'(i) * 64'sd1686629713) / 64'sd255;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 6; k++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
            sum  = sum + term;
        end
        r = (sum * 64'sd511 + (64'sd1 <<< 29)) >>> 30;
        if (r > 64'sd511) r = 64'sd511;
        if (r < 64'sd0)   r = 64'sd0;
        return r[8:0];
    endfunction

    logic [8:0] rom [256];

    for (genvar g = 0; g < 256; g++) begin : g_rom
        assign rom[g] = sine_mag(g);
    end

    assign mag = rom[idx];

endmodule

// File: rtl/dds_wavegen.sv
// DDS waveform source: phase accumulator advanced by a tuning word on each
// sample tick, then mapped to saw / triangle / square / sine. Produces a
// held DATA_W sample and a one-cycle load strobe two cycles after tick.
// Optional feature macro: DDS_SINE_EN (sine on wave_sel=11 from a
// quarter-wave ROM; otherwise wave_sel=11 gives constant mid-scale).
// On the board, tick comes from clktick_16, ftw from SW, and
// data_out/load feed pwm and spi2dac.
module dds_wavegen
    import dds_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int FTW_W  = FTW_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              tick,
    input  logic [FTW_W-1:0]  ftw,
    input  logic [1:0]        wave_sel,
    input  logic              phase_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              load
);

    localparam logic [DATA_W-1:0] MID = DATA_W'(MIDSCALE);

    // Mid-scale offset by a signed-less magnitude; 0x200 +/- 511 never wraps.
    function automatic logic [DATA_W-1:0] sine_fold(input logic neg_half,
                                                    input logic [8:0] m);
        return neg_half ? (MID - DATA_W'(m)) : (MID + DATA_W'(m));
    endfunction

    logic [ACC_W-1:0]  acc_p1;
    logic [1:0]        sel_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] phase_p1;
    logic [DATA_W-1:0] wave_p1;

    // Stage 1: phase accumulate (clear wins over tick), capture shape select.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            acc_p1 <= '0;
            sel_p1 <= WAVE_SAW;
            vld_p1 <= 1'b0;
        end else begin
            if (phase_clr) begin
                acc_p1 <= '0;
            end else if (tick) begin
                acc_p1 <= acc_p1 + ACC_W'(ftw);
            end
            if (tick) begin
                sel_p1 <= wave_sel;
            end
            vld_p1 <= tick;
        end
    end

    assign phase_p1 = acc_p1[ACC_W-1 -: DATA_W];

`ifdef DDS_SINE_EN
    logic [7:0] sine_idx;
    logic [8:0] sine_m;

    // Second quadrant of each half-cycle reads the table backwards.
    assign sine_idx = phase_p1[DATA_W-2] ? ~phase_p1[DATA_W-3 -: 8]
                                         :  phase_p1[DATA_W-3 -: 8];

    sine_qrom u_sine_qrom (
        .idx (sine_idx),
        .mag (sine_m)
    );
`endif

    // Stage 2 shaping: map the top phase bits to the selected waveform.
    always_comb begin
        wave_p1 = MID;
        case (sel_p1)
            WAVE_SAW: wave_p1 = phase_p1;
            WAVE_TRI: wave_p1 = phase_p1[DATA_W-1]
                                ? {~phase_p1[DATA_W-2:0], 1'b0}
                                : { phase_p1[DATA_W-2:0], 1'b0};
            WAVE_SQR: wave_p1 = phase_p1[DATA_W-1] ? '0 : '1;
            WAVE_SINE: begin
`ifdef DDS_SINE_EN
                wave_p1 = sine_fold(phase_p1[DATA_W-1], sine_m);
`else
                wave_p1 = MID;
`endif
            end
            default: wave_p1 = MID;
        endcase
    end

    // Stage 2 register: hold the sample between loads, strobe load once.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            data_out <= MID;
            load     <= 1'b0;
        end else begin
            load <= vld_p1;
            if (vld_p1) begin
                data_out <= wave_p1;
            end
        end
    end

endmodule

// File: tb/tb_dds_wavegen.sv
// Scoreboard bench for dds_wavegen: stimulus pushes expected samples with
// their due cycle, a negedge monitor pops and checks on every load.
module tb_dds_wavegen;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [9:0] ftw;
    logic [1:0] wave_sel;
    logic       phase_clr;
    logic [9:0] data_out;
    logic       load;

    dds_wavegen dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .tick      (tick),
        .ftw       (ftw),
        .wave_sel  (wave_sel),
        .phase_clr (phase_clr),
        .data_out  (data_out),
        .load      (load)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     lo;
        int     hi;
        longint due;
        bit     chk;
    } exp_t;

    exp_t        sbq[$];
    longint      cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] acc_m;
    int          last = 'h200;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act,
                         input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            if (lo == hi)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, lo, cyc);
            else
                $display("FAIL %s: got 0x%0h, expected 0x%0h..0x%0h (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Spec-level shape model written arithmetically.
    function automatic int shape(input int p, input logic [1:0] s);
        case (s)
            2'b00:   return p;
            2'b01:   return (p < 512) ? 2 * p : 2 * (1023 - p);
            2'b10:   return (p < 512) ? 1023 : 0;
            default: return 'h200;
        endcase
    endfunction

    // Monitor: every load pops one expectation; no load means data holds.
    always @(negedge clk) begin
        if (rst) begin
            last = 'h200;
        end else if (load) begin
            if (sbq.size() == 0) begin
                check("unexpected_load", 1, 0, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("load_latency", cyc, e.due, e.due);
                if (e.chk) check("sample", longint'(data_out), e.lo, e.hi);
            end
            last = int'(data_out);
        end else begin
            check("hold", longint'(data_out), last, last);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // lo >= 0: explicit range; lo == -1: shape model; lo == -2: not checked.
    task automatic do_tick(input logic [9:0] f, input logic [1:0] s, input bit clr,
                           input int lo, input int hi, input bit push);
        exp_t e;
        int   p;
        if (clr) acc_m = 16'h0000;
        else     acc_m = acc_m + {6'd0, f};
        p     = int'(acc_m[15:6]);
        e.due = cyc + 2;
        e.chk = (lo != -2);
        if (lo >= 0) begin
            e.lo = lo;
            e.hi = hi;
        end else begin
            e.lo = shape(p, s);
            e.hi = e.lo;
        end
        if (push) sbq.push_back(e);
        ftw       = f;
        wave_sel  = s;
        phase_clr = clr;
        tick      = 1'b1;
        @(posedge clk);
        #1;
        tick      = 1'b0;
        phase_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; ftw = '0; wave_sel = 2'b00; phase_clr = 1'b0;
        acc_m = 16'h0000;
        idle(3);
        check("reset_data", longint'(data_out), 'h200, 'h200);
        check("reset_load", longint'(load), 0, 0);
        rst = 1'b0;
        idle(3);
        check("pre_first_load", longint'(data_out), 'h200, 'h200);

        // Saw, ftw 0x040, tick every 4 cycles: 1, 2, 3, 4, 5.
        for (int i = 1; i <= 5; i++) begin
            do_tick(10'h040, 2'b00, 1'b0, i, i, 1'b1);
            idle(3);
        end

        // ftw 0 re-emits the same sample with load still pulsing.
        do_tick(10'h000, 2'b00, 1'b0, 5, 5, 1'b1);
        idle(2);
        do_tick(10'h000, 2'b00, 1'b0, 5, 5, 1'b1);
        idle(2);

        // phase_clr with tick emits phase 0; then 3 back-to-back ticks.
        do_tick(10'h040, 2'b00, 1'b1, 0, 0, 1'b1);
        do_tick(10'h040, 2'b00, 1'b0, 1, 1, 1'b1);
        do_tick(10'h040, 2'b00, 1'b0, 2, 2, 1'b1);
        do_tick(10'h040, 2'b00, 1'b0, 3, 3, 1'b1);
        idle(3);

        // phase_clr alone clears without emitting; next tick restarts at 1.
        phase_clr = 1'b1;
        acc_m     = 16'h0000;
        idle(1);
        phase_clr = 1'b0;
        idle(2);
        do_tick(10'h040, 2'b00, 1'b0, 1, 1, 1'b1);
        idle(2);

        // Wrap: 64 x 0x3FF = 0xFFC0 (p = 0x3FF), then +0x080 -> 0x0040 (p = 1).
        do_tick(10'h3FF, 2'b00, 1'b1, 0, 0, 1'b1);
        for (int i = 1; i < 64; i++) do_tick(10'h3FF, 2'b00, 1'b0, -1, -1, 1'b1);
        do_tick(10'h3FF, 2'b00, 1'b0, 'h3FF, 'h3FF, 1'b1);
        do_tick(10'h080, 2'b00, 1'b0, 'h001, 'h001, 1'b1);
        idle(3);

        // Triangle with phase step 8: 0, 16, 32, ... 1008, 1022, 1006, ...
        do_tick(10'h200, 2'b01, 1'b1, 0, 0, 1'b1);
        do_tick(10'h200, 2'b01, 1'b0, 16, 16, 1'b1);
        do_tick(10'h200, 2'b01, 1'b0, 32, 32, 1'b1);
        for (int i = 3; i < 64; i++) do_tick(10'h200, 2'b01, 1'b0, -1, -1, 1'b1);
        do_tick(10'h200, 2'b01, 1'b0, 1022, 1022, 1'b1);
        do_tick(10'h200, 2'b01, 1'b0, 1006, 1006, 1'b1);
        for (int i = 66; i < 130; i++) do_tick(10'h200, 2'b01, 1'b0, -1, -1, 1'b1);
        idle(3);

        // Square: 0x3FF for p < 512, 0x000 from p = 512.
        do_tick(10'h200, 2'b10, 1'b1, 'h3FF, 'h3FF, 1'b1);
        for (int i = 1; i < 64; i++) do_tick(10'h200, 2'b10, 1'b0, -1, -1, 1'b1);
        do_tick(10'h200, 2'b10, 1'b0, 0, 0, 1'b1);
        do_tick(10'h200, 2'b10, 1'b0, 0, 0, 1'b1);
        idle(3);

        // Shape select changes only affect ticks issued after the change.
        do_tick(10'h040, 2'b00, 1'b1, 0, 0, 1'b1);
        do_tick(10'h040, 2'b10, 1'b0, 'h3FF, 'h3FF, 1'b1);
        do_tick(10'h040, 2'b00, 1'b0, 2, 2, 1'b1);
        idle(3);

        // Reset one cycle after a tick discards that sample.
        do_tick(10'h100, 2'b00, 1'b0, 0, 0, 1'b0);
        rst = 1'b1;
        idle(1);
        rst   = 1'b0;
        acc_m = 16'h0000;
        check("reset_flush_data", longint'(data_out), 'h200, 'h200);
        idle(4);
        do_tick(10'h040, 2'b00, 1'b0, 1, 1, 1'b1);
        idle(3);

`ifdef DDS_SINE_EN
        // Sine: 0x200 at p=0, peak at p=256, 0x200 at p=512, trough at p=768.
        do_tick(10'h040, 2'b11, 1'b1, 'h200, 'h200, 1'b1);
        for (int i = 1; i <= 768; i++) begin
            if (i == 256)      do_tick(10'h040, 2'b11, 1'b0, 'h3F8, 'h3FF, 1'b1);
            else if (i == 512) do_tick(10'h040, 2'b11, 1'b0, 'h200, 'h200, 1'b1);
            else if (i == 768) do_tick(10'h040, 2'b11, 1'b0, 'h000, 'h008, 1'b1);
            else               do_tick(10'h040, 2'b11, 1'b0, -2, -2, 1'b1);
        end
`else
        // Without the sine option, select 11 is a constant mid-scale.
        do_tick(10'h040, 2'b11, 1'b1, 'h200, 'h200, 1'b1);
        for (int i = 1; i <= 8; i++) do_tick(10'h100, 2'b11, 1'b0, 'h200, 'h200, 1'b1);
`endif
        idle(3);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) idle(1);
        check("pending_loads", longint'(sbq.size()), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_wavegen.md
# dds_wavegen

Direct-digital-synthesis waveform source that produces the 10-bit sample stream and one-cycle load strobe consumed by the `pwm` and `spi2dac` stages. It sits between the tick divider (`clktick_16`) and the output converters, replacing the static switch value with a periodic waveform. A phase accumulator advances by a tuning word on each sample tick. The phase is then mapped to a selectable waveform shape.

## Interface

Parameters:
- `ACC_W`, 16: phase accumulator width.
- `DATA_W`, 10: sample width; must match the `spi2dac` and `pwm` data width.
- `FTW_W`, 10: frequency tuning word width; must be ≤ `ACC_W`.

Ports:
- `CLOCK_50`, in, 1: system clock; the only clock.
- `RESET`, in, 1: asynchronous, active-high reset.
- `tick`, in, 1: sample strobe, one cycle wide, from `clktick_16`.
- `ftw`, in, `FTW_W`: frequency tuning word, zero-extended to `ACC_W`.
- `wave_sel`, in, 2: waveform shape select.
- `phase_clr`, in, 1: synchronous accumulator clear.
- `data_out`, out, `DATA_W`: current sample, held between loads.
- `load`, out, 1: one-cycle pulse marking a new `data_out`; drives the converter `load` inputs.

## Operation

- Stage 1 fires on a cycle with `tick`=1:
  - `acc <= acc + ftw`, modulo 2^ACC_W, so wrap-around is silent.
  - `wave_sel` is captured into a stage register.
  - A stage-1 valid flag is set.
- `phase_clr`=1 sets `acc <= 0` and takes priority over `tick`.
  - If `phase_clr` and `tick` are both high, a sample is still emitted, using phase 0.
- Stage 2 fires on a cycle with stage-1 valid. It takes the phase `p = acc[ACC_W-1 -: DATA_W]` (top 10 bits) and produces:
  - `wave_sel`=00, sawtooth: `p`.
  - `wave_sel`=01, triangle: `{p[8:0],1'b0}` if `p[9]`=0, else `{~p[8:0],1'b0}`. Range 0..1022.
  - `wave_sel`=10, square: 0x3FF if `p[9]`=0, else 0x000.
  - `wave_sel`=11: sine (see Configuration).
- `data_out` is registered, and `load` is registered high for exactly one cycle.
- `ftw` and `wave_sel` changes affect only samples whose tick is on or after the change; in-flight samples are unaffected.

## Timing

- Reset values:
  - `acc` = 0.
  - Stage-1 valid = 0.
  - `data_out` = 0x200 (mid-scale).
  - `load` = 0.
- Latency: `tick` high in cycle n gives `load` high in cycle n+2, with the new `data_out` visible from cycle n+2.
- `data_out` is stable until the next `load`.
- The pipeline is fully pipelined. `tick` on consecutive cycles gives `load` on consecutive cycles, and no sample is dropped.
- `RESET` during operation discards in-flight samples. No `load` is produced for a tick accepted before reset.
- `ftw`=0 makes every tick re-emit the same sample, and `load` still pulses.

## Configuration

- Macro `DDS_SINE_EN`:
  - Defined: `wave_sel`=11 outputs sine, computed combinationally in stage 2 from a quarter-wave ROM.
    - The ROM has 256 entries × 9-bit magnitude `m`.
    - The ROM index is `p[7:0]` when `p[8]`=0, else `~p[7:0]`.
    - The output is `0x200 + m` when `p[9]`=0, else `0x200 - m`.
  - Not defined: `wave_sel`=11 outputs the constant 0x200, and no ROM is instantiated.

## Structure

- Shared package `dds_pkg` holds:
  - Wave-select constants `WAVE_SAW`, `WAVE_TRI`, `WAVE_SQR`, `WAVE_SINE`.
  - `MIDSCALE` (0x200).
  - Default widths.
- Sub-module `sine_qrom` holds the combinational 256×9 quarter-wave table and is instantiated only under `DDS_SINE_EN`.
- Top-level integration:
  - `tick` comes from `clktick_16`.
  - `ftw` comes from `SW`.
  - `data_out` and `load` go to `pwm` and `spi2dac` in place of `SW` and `tick`.

## Test plan

- Reset release, then `ftw`=0x040, saw, ticks every 4 cycles:
  - Expect `load` 2 cycles after each tick.
  - Expect `data_out` = 1, 2, 3, …
  - Expect `data_out` = 0x200 before the first load.
- Wrap-around: preload `acc` to 0xFFC0 via ticks, then `ftw`=0x080 → `acc`=0x0040, `data_out`=0x001 (saw).
- Triangle, `ftw`=0x200 (phase step 8):
  - Samples rise 16, 32, … up to 1022, then fall symmetrically.
  - Square at `p[9]` toggles 0x3FF to 0x000.
- `tick` asserted 3 consecutive cycles → 3 consecutive `load` pulses with distinct, correctly ordered samples.
- `phase_clr` with `tick` in the same cycle → `acc`=0 and the emitted sample is 0x000 (saw).
- `RESET` pulsed in cycle n+1 after a tick in cycle n → no `load` in n+2, `data_out`=0x200.
- With `DDS_SINE_EN` defined, `wave_sel`=11, `ftw`=0x040:
  - Expect 0x200 at `p`=0, peak near 0x3FF at `p`=256, and ≈0x000 at `p`=768.
  - With the macro undefined, expect a constant 0x200.
